// File: rtl/lif_neuron_scheduler.sv
// lif_neuron_scheduler
//   Time-multiplexes one shared LIF datapath across N_NEURONS virtual neurons.
//   Each neuron keeps its config (w, shift, minus_teta) and state (u, was_spike)
//   in its own lane instance. A timestep request walks every neuron in index
//   order. Each neuron gets a slot of NRN_LAT+1 cycles, and the datapath result
//   is captured on the last cycle of its slot. The spike vector is published
//   on step_done.
//
// Optional feature (macro LIF_SCHED_REFRACTORY_EN, parameter REFRACT_STEPS):
//   Each neuron gets a 3-bit refractory counter that is loaded when it spikes.
//   While the counter is nonzero the neuron's input is forced to 0 and its
//   result is discarded (u=0, no spike). The counter counts down once per
//   timestep.
//
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   cfg_we/cfg_addr/cfg_w/cfg_shift/    per-neuron config write; accepted only
//   cfg_minus_teta                      when idle
//   step_start, x_in                    timestep request and packed inputs
//   step_busy, step_done, spikes_out    step status and last spike vector
//   nrn_*  (out)                        operands to the shared datapath
//   nrn_u_out, nrn_is_spike (in)        datapath results

module lif_sched_lane #(
  parameter int W_W = 2,
  parameter int U_W = 3
`ifdef LIF_SCHED_REFRACTORY_EN
  , parameter int REFRACT_STEPS = 2
`endif
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cfg_we,
  input  logic [W_W-1:0] cfg_w,
  input  logic [U_W-1:0] cfg_shift,
  input  logic [U_W-1:0] cfg_minus_teta,
  input  logic           cap_en,
  input  logic [U_W-1:0] cap_u,
  input  logic           cap_spike,
  output logic [W_W-1:0] w,
  output logic [U_W-1:0] shift,
  output logic [U_W-1:0] minus_teta,
  output logic [U_W-1:0] u,
  output logic           was_spike,
  output logic           refr_active
);

`ifdef LIF_SCHED_REFRACTORY_EN
  logic [2:0] refr;
  assign refr_active = (refr != 3'd0);
`else
  assign refr_active = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      w          <= W_W'(1);
      shift      <= U_W'(1);
      minus_teta <= U_W'(5);
      u          <= '0;
      was_spike  <= 1'b0;
`ifdef LIF_SCHED_REFRACTORY_EN
      refr       <= 3'd0;
`endif
    end else begin
      if (cfg_we) begin
        w          <= cfg_w;
        shift      <= cfg_shift;
        minus_teta <= cfg_minus_teta;
      end
      if (cap_en) begin
`ifdef LIF_SCHED_REFRACTORY_EN
        if (refr_active) begin
          // A refractory neuron's datapath result is discarded.
          u         <= '0;
          was_spike <= 1'b0;
          refr      <= refr - 3'd1;
        end else begin
          u         <= cap_u;
          was_spike <= cap_spike;
          if (cap_spike) refr <= 3'(REFRACT_STEPS);
        end
`else
        u         <= cap_u;
        was_spike <= cap_spike;
`endif
      end
    end
  end

endmodule

module lif_neuron_scheduler #(
  parameter int N_NEURONS = 4,
  parameter int IDX_W     = 2,
  parameter int X_W       = 2,
  parameter int W_W       = 2,
  parameter int U_W       = 3,
  parameter int NRN_LAT   = 1
`ifdef LIF_SCHED_REFRACTORY_EN
  , parameter int REFRACT_STEPS = 2
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_we,
  input  logic [IDX_W-1:0]         cfg_addr,
  input  logic [W_W-1:0]           cfg_w,
  input  logic [U_W-1:0]           cfg_shift,
  input  logic [U_W-1:0]           cfg_minus_teta,
  input  logic                     step_start,
  input  logic [N_NEURONS*X_W-1:0] x_in,
  output logic                     step_busy,
  output logic                     step_done,
  output logic [N_NEURONS-1:0]     spikes_out,
  output logic [W_W-1:0]           nrn_w,
  output logic [X_W-1:0]           nrn_x,
  output logic [U_W-1:0]           nrn_shift,
  output logic [U_W-1:0]           nrn_previus_u,
  output logic [U_W-1:0]           nrn_minus_teta,
  output logic                     nrn_was_spike,
  input  logic [U_W-1:0]           nrn_u_out,
  input  logic                     nrn_is_spike
);

  localparam int LAT_W = (NRN_LAT > 1) ? $clog2(NRN_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                          state;
  logic [IDX_W-1:0]                idx;
  logic [LAT_W-1:0]                wait_cnt;
  logic [N_NEURONS-1:0][X_W-1:0]   x_q;
  logic [N_NEURONS-1:0]            spike_acc;
  logic [N_NEURONS-1:0]            spikes_q;

  logic [N_NEURONS-1:0][W_W-1:0]   w_all;
  logic [N_NEURONS-1:0][U_W-1:0]   shift_all;
  logic [N_NEURONS-1:0][U_W-1:0]   teta_all;
  logic [N_NEURONS-1:0][U_W-1:0]   u_all;
  logic [N_NEURONS-1:0]            was_all;
  logic [N_NEURONS-1:0]            refr_all;

  logic cfg_wr;
  logic slot_last;

  // Config is frozen while a step runs.
  assign cfg_wr = cfg_we && (state == IDLE);

  // Last cycle of the current neuron's slot: the datapath result is valid here.
  assign slot_last = ((state == ISSUE) && (NRN_LAT == 0)) ||
                     ((state == WAIT) && (wait_cnt == LAT_W'(NRN_LAT - 1)));

  // Each lane matches only its own index. An out-of-range cfg_addr
  // therefore hits no lane and the write is dropped.
  for (genvar i = 0; i < N_NEURONS; i++) begin : g_lane
    lif_sched_lane #(
      .W_W(W_W), .U_W(U_W)
`ifdef LIF_SCHED_REFRACTORY_EN
      , .REFRACT_STEPS(REFRACT_STEPS)
`endif
    ) u_lane (
      .clk            (clk),
      .reset          (reset),
      .cfg_we         (cfg_wr && (cfg_addr == IDX_W'(i))),
      .cfg_w          (cfg_w),
      .cfg_shift      (cfg_shift),
      .cfg_minus_teta (cfg_minus_teta),
      .cap_en         (slot_last && (idx == IDX_W'(i))),
      .cap_u          (nrn_u_out),
      .cap_spike      (nrn_is_spike),
      .w              (w_all[i]),
      .shift          (shift_all[i]),
      .minus_teta     (teta_all[i]),
      .u              (u_all[i]),
      .was_spike      (was_all[i]),
      .refr_active    (refr_all[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      wait_cnt  <= '0;
      x_q       <= '0;
      spike_acc <= '0;
      spikes_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (step_start) begin
            x_q   <= x_in;
            idx   <= '0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          if (NRN_LAT != 0) state <= WAIT;
        end
        WAIT: wait_cnt <= wait_cnt + LAT_W'(1);
        DONE: begin
          spikes_q  <= spike_acc;
          spike_acc <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // End of slot takes priority over the per-state defaults above.
      if (slot_last) begin
        spike_acc[idx] <= nrn_is_spike && !refr_all[idx];
        if (idx == IDX_W'(N_NEURONS - 1)) begin
          state <= DONE;
        end else begin
          idx   <= idx + IDX_W'(1);
          state <= ISSUE;
        end
      end
    end
  end

  // Operands are decoded from registered state only, so they stay stable
  // for the whole slot.
  always_comb begin
    nrn_w          = '0;
    nrn_x          = '0;
    nrn_shift      = '0;
    nrn_previus_u  = '0;
    nrn_minus_teta = '0;
    nrn_was_spike  = 1'b0;
    if (state == ISSUE || state == WAIT) begin
      nrn_w          = w_all[idx];
      nrn_x          = refr_all[idx] ? '0 : x_q[idx];
      nrn_shift      = shift_all[idx];
      nrn_previus_u  = u_all[idx];
      nrn_minus_teta = teta_all[idx];
      nrn_was_spike  = was_all[idx];
    end
  end

  assign step_busy  = (state != IDLE);
  assign step_done  = (state == DONE);
  assign spikes_out = spikes_q;

endmodule

// File: doc/lif_neuron_scheduler.md
Name: lif_neuron_scheduler

Overview:
Time-multiplexes one LIF neuron datapath across N_NEURONS virtual neurons. Holds per-neuron config (w, shift, minus_teta) and state (membrane u, was_spike) in register banks. On each timestep request, issues every neuron to the shared datapath in index order, captures u_out/is_spike, writes them back, and reports the spike vector. Sits between the top-level tile I/O and the neuron instance.

Parameters:
N_NEURONS, 4, number of virtual neurons (2..16)
IDX_W, 2, index width = clog2(N_NEURONS)
X_W, 2, per-neuron input width
W_W, 2, weight width
U_W, 3, membrane / shift / minus_teta width
NRN_LAT, 1, datapath pipeline depth in cycles (n_stage); 0 = combinational

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
cfg_we  in  1  config write strobe
cfg_addr  in  IDX_W  neuron index for config write
cfg_w  in  W_W  weight to store
cfg_shift  in  U_W  leak shift to store
cfg_minus_teta  in  U_W  threshold to store
step_start  in  1  request one timestep
x_in  in  N_NEURONS*X_W  inputs, neuron i at [i*X_W +: X_W]
step_busy  out  1  timestep in progress
step_done  out  1  one-cycle pulse at timestep end
spikes_out  out  N_NEURONS  spike vector of last completed timestep
nrn_w  out  W_W  to datapath w
nrn_x  out  X_W  to datapath x
nrn_shift  out  U_W  to datapath shift
nrn_previus_u  out  U_W  to datapath previus_u
nrn_minus_teta  out  U_W  to datapath minus_teta
nrn_was_spike  out  1  to datapath was_spike
nrn_u_out  in  U_W  from datapath u_out
nrn_is_spike  in  1  from datapath is_spike

Behaviour:
- Reset (sync, active-high, wins over everything): all neurons w=1, shift=1, minus_teta=5, u=0, was_spike=0; FSM IDLE; step_busy=0, step_done=0, spikes_out=0; all nrn_* outputs 0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: step_start=1 latches x_in into x_q, idx=0, -> ISSUE. cfg_we=1 writes config for cfg_addr. cfg_addr >= N_NEURONS: write ignored. Simultaneous cfg_we and step_start: write occurs first; the new config is used by this step.
- ISSUE (1 cycle) then WAIT (NRN_LAT cycles; skipped when NRN_LAT=0): nrn_* driven from bank[idx] and x_q[idx], held stable all L+1 cycles (L=NRN_LAT).
- Last cycle of a neuron slot: capture nrn_u_out -> u[idx], nrn_is_spike -> was_spike[idx] and spike_acc[idx]. idx==N_NEURONS-1 -> DONE, else idx+1 -> ISSUE.
- DONE (1 cycle): step_done=1, spikes_out<=spike_acc, spike_acc cleared, -> IDLE.
- Timing: step_start sampled at edge k -> step_busy=1 from cycle k+1 through the DONE cycle. DONE occupies cycle k+1+N_NEURONS*(L+1). Next start accepted the cycle after DONE.
- step_start while busy: ignored, no queueing. cfg_we while busy: ignored (config stable during step).
- Outside ISSUE/WAIT, nrn_* = 0.
- spikes_out holds until the next DONE or reset.
- Reset mid-step: abort immediately, no step_done, all banks return to defaults.
- Widths: u stored exactly as returned (U_W bits, no wrap correction). Saturation is the datapath's job.

Optional Feature:
Macro LIF_SCHED_REFRACTORY_EN, with parameter REFRACT_STEPS default 2 (1..7).
- Defined: a 3-bit refractory counter per neuron, loaded with REFRACT_STEPS when that neuron spikes. While the counter is nonzero:
  - the neuron's slot still occupies L+1 cycles, but nrn_x is forced to 0;
  - captured u is forced to 0 and its spike is forced to 0;
  - the counter decrements once per timestep, at that neuron's capture.
- Reset clears all counters.
- Undefined: no counters; every neuron is evaluated every step.

Test Plan:
- Reset -> step_busy=0, spikes_out=0. First step with a pass-through stub datapath shows nrn_w=1, nrn_shift=1, nrn_minus_teta=5, nrn_previus_u=0 for every idx.
- cfg_we, addr=2, w=3, shift=2, teta=6, in IDLE; then step -> during slot 2, nrn_w=3, nrn_shift=2, nrn_minus_teta=6. Slots 0, 1 and 3 keep the defaults.
- N=4, L=1, step_start pulsed at edge 0 -> step_busy=1 on cycles 1..9, step_done pulse exactly at cycle 9, each nrn_* slot 2 cycles long.
- Stub returns is_spike=1, u_out=0 for idx 2, else u_out=idx+1 -> spikes_out=4'b0100. On the next step, slot 2 has nrn_was_spike=1 and slot 1 has nrn_previus_u=2.
- step_start and cfg_we asserted at cycle 4 of a step -> both ignored, done still at cycle 9. Reset at cycle 5 -> no done, defaults restored.
- LIF_SCHED_REFRACTORY_EN, REFRACT_STEPS=2: neuron 1 spikes in step 0 -> in steps 1 and 2, slot 1 has nrn_x=0 and spikes_out[1]=0; in step 3, normal evaluation resumes.
